// File: rtl/rbus_eject.sv
// rbus_eject: ring stop that sits directly after an rbus ring-merge stage.
//
// Purpose:
//   Beats addressed to this tile are copied into a small receive FIFO.
//   Their ring copy is retired by clearing the `RBUS_USED bit.
//   All other beats are forwarded unchanged through one register.
//   in_can throttles the upstream stage's injection while the FIFO is
//   nearly full.
//
// Configuration macro: RBUS_EJECT_BYPASS_EN
//   When defined, a matching beat that arrives at an empty FIFO while the
//   tile is ready is handed straight to ej_* in the same cycle. That beat
//   is never written into the FIFO.
//
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   rbusIn_*             beat from the upstream merge stage
//   rbusOut_*            registered beat to the next ring stage
//   in_can               to upstream next_in_can (1 = may inject)
//   ej_valid/ej_ready    receive FIFO head handshake
//   ej_signals/src/addr  receive FIFO head contents
//   ej_count             FIFO occupancy
//   ej_overflow          sticky: a matching beat found the FIFO full

`ifndef RBUS_WIDTH
`define RBUS_WIDTH 4
`endif
`ifndef RBUS_USED
`define RBUS_USED 0
`endif
`ifndef RBUS_SECOND
`define RBUS_SECOND 1
`endif

module rbus_eject #(
    parameter logic [4:0] ID    = 5'd0,
    parameter int         DEPTH = 4,               // power of 2, 2..16
    parameter int         CW    = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [`RBUS_WIDTH-1:0] rbusIn_signals,
    input  logic [9:0]             rbusIn_src_req,
    input  logic [9:0]             rbusIn_dst_req,
    input  logic [36:0]            rbusIn_address,
    output logic [`RBUS_WIDTH-1:0] rbusOut_signals,
    output logic [9:0]             rbusOut_src_req,
    output logic [9:0]             rbusOut_dst_req,
    output logic [36:0]            rbusOut_address,
    output logic                   in_can,
    output logic                   ej_valid,
    input  logic                   ej_ready,
    output logic [`RBUS_WIDTH-1:0] ej_signals,
    output logic [9:0]             ej_src_req,
    output logic [36:0]            ej_address,
    output logic [CW-1:0]          ej_count,
    output logic                   ej_overflow
);

    localparam int            AW          = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
    localparam logic [CW-1:0] INCAN_MAX_C = CW'(DEPTH - 2);
    localparam logic [CW-1:0] CNT_ONE_C   = CW'(1);
    localparam logic [AW-1:0] PTR_ONE_C   = AW'(1);
    localparam logic [9:0]    MY_ID_C     = {5'b00000, ID};

    // Receive FIFO storage and bookkeeping
    logic [`RBUS_WIDTH-1:0] sig_mem_r  [DEPTH];
    logic [9:0]             src_mem_r  [DEPTH];
    logic [36:0]            addr_mem_r [DEPTH];
    logic [AW-1:0]          wr_ptr_r;
    logic [AW-1:0]          rd_ptr_r;
    logic [CW-1:0]          count_r;
    logic [CW-1:0]          count_nxt_s;
    logic                   overflow_r;

    // Forward register
    logic [`RBUS_WIDTH-1:0] fwd_sig_r;
    logic [9:0]             fwd_src_r;
    logic [9:0]             fwd_dst_r;
    logic [36:0]            fwd_addr_r;
    logic [`RBUS_WIDTH-1:0] fwd_sig_s;

    // Control
    logic match_s;
    logic fifo_pop_s;
    logic bypass_s;
    logic push_s;
    logic drop_s;

    // Decode match, bypass, push and pop for the current beat
    always_comb begin
        match_s    = rbusIn_signals[`RBUS_USED] && (rbusIn_dst_req == MY_ID_C);
        fifo_pop_s = (count_r != '0) && ej_ready;
`ifdef RBUS_EJECT_BYPASS_EN
        bypass_s   = match_s && (count_r == '0) && ej_ready;
`else
        bypass_s   = 1'b0;
`endif
        // A pop in the same cycle frees the slot, so a full FIFO still
        // accepts the beat.
        push_s     = match_s && !bypass_s && ((count_r < DEPTH_C) || fifo_pop_s);
        // A refused beat stays on the ring and comes round again.
        drop_s     = match_s && !bypass_s && !push_s;
    end

    // Forwarded copy: the used bit is retired only when this tile consumed the beat
    always_comb begin
        fwd_sig_s = rbusIn_signals;
        if (push_s || bypass_s) begin
            fwd_sig_s[`RBUS_USED] = 1'b0;
        end else begin
            fwd_sig_s[`RBUS_USED] = rbusIn_signals[`RBUS_USED];
        end
    end

    // Next occupancy: simultaneous push and pop leaves the count unchanged
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, fifo_pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE_C;
            2'b01:   count_nxt_s = count_r - CNT_ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // Forward register loads every cycle, no stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_sig_r  <= '0;
            fwd_src_r  <= 10'd0;
            fwd_dst_r  <= 10'd0;
            fwd_addr_r <= 37'd0;
        end else begin
            fwd_sig_r  <= fwd_sig_s;
            fwd_src_r  <= rbusIn_src_req;
            fwd_dst_r  <= rbusIn_dst_req;
            fwd_addr_r <= rbusIn_address;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (fifo_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // FIFO storage; cleared on reset so stale beats can never resurface
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sig_mem_r[i]  <= '0;
                src_mem_r[i]  <= 10'd0;
                addr_mem_r[i] <= 37'd0;
            end
        end else if (push_s) begin
            sig_mem_r[wr_ptr_r]  <= rbusIn_signals;
            src_mem_r[wr_ptr_r]  <= rbusIn_src_req;
            addr_mem_r[wr_ptr_r] <= rbusIn_address;
        end else begin
            sig_mem_r[wr_ptr_r]  <= sig_mem_r[wr_ptr_r];
            src_mem_r[wr_ptr_r]  <= src_mem_r[wr_ptr_r];
            addr_mem_r[wr_ptr_r] <= addr_mem_r[wr_ptr_r];
        end
    end

    // Eject port: FIFO head, or the live input beat when the FIFO is empty in bypass builds
    always_comb begin
        ej_valid   = (count_r != '0);
        ej_signals = sig_mem_r[rd_ptr_r];
        ej_src_req = src_mem_r[rd_ptr_r];
        ej_address = addr_mem_r[rd_ptr_r];
`ifdef RBUS_EJECT_BYPASS_EN
        if ((count_r == '0) && match_s) begin
            ej_valid   = 1'b1;
            ej_signals = rbusIn_signals;
            ej_src_req = rbusIn_src_req;
            ej_address = rbusIn_address;
        end else begin
            ej_valid   = (count_r != '0);
        end
`endif
    end

    // Remaining outputs come straight from registers; in_can keeps two slots of slack
    assign rbusOut_signals = fwd_sig_r;
    assign rbusOut_src_req = fwd_src_r;
    assign rbusOut_dst_req = fwd_dst_r;
    assign rbusOut_address = fwd_addr_r;
    assign ej_count        = count_r;
    assign ej_overflow     = overflow_r;
    assign in_can          = (count_r <= INCAN_MAX_C);

endmodule

// File: tb/tb_rbus_eject.sv
// Self-checking bench for rbus_eject (ID=3, DEPTH=4).
// A table of beats is applied one per cycle. Each record gives the expected
// forwarded used bit, count, in_can and overflow after the clock edge.
// Every beat the table marks as accepted is queued on a scoreboard. The
// queue is checked against ej_* whenever the tile pops.

`ifndef RBUS_WIDTH
`define RBUS_WIDTH 4
`endif
`ifndef RBUS_USED
`define RBUS_USED 0
`endif
`ifndef RBUS_SECOND
`define RBUS_SECOND 1
`endif

module tb_rbus_eject;

    localparam int NV = 26;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [`RBUS_WIDTH-1:0] rbusIn_signals;
    logic [9:0]             rbusIn_src_req;
    logic [9:0]             rbusIn_dst_req;
    logic [36:0]            rbusIn_address;
    logic [`RBUS_WIDTH-1:0] rbusOut_signals;
    logic [9:0]             rbusOut_src_req;
    logic [9:0]             rbusOut_dst_req;
    logic [36:0]            rbusOut_address;
    logic                   in_can;
    logic                   ej_valid;
    logic                   ej_ready;
    logic [`RBUS_WIDTH-1:0] ej_signals;
    logic [9:0]             ej_src_req;
    logic [36:0]            ej_address;
    logic [2:0]             ej_count;
    logic                   ej_overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        used;
        logic [9:0]  dst;
        logic [36:0] addr;
        logic        rdy;
        logic        eUsed;
        logic [2:0]  eCnt;
        logic        eInCan;
        logic        eOvf;
    } vec_t;

    vec_t        vecs [NV];
    logic [46:0] sb [$];

    rbus_eject #(.ID(5'd3), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .rbusIn_signals(rbusIn_signals), .rbusIn_src_req(rbusIn_src_req),
        .rbusIn_dst_req(rbusIn_dst_req), .rbusIn_address(rbusIn_address),
        .rbusOut_signals(rbusOut_signals), .rbusOut_src_req(rbusOut_src_req),
        .rbusOut_dst_req(rbusOut_dst_req), .rbusOut_address(rbusOut_address),
        .in_can(in_can), .ej_valid(ej_valid), .ej_ready(ej_ready),
        .ej_signals(ej_signals), .ej_src_req(ej_src_req),
        .ej_address(ej_address), .ej_count(ej_count),
        .ej_overflow(ej_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic used, input logic [9:0] dst, input logic [36:0] addr, input logic rdy);
        rbusIn_signals = {2'b10, 1'b0, used};
        rbusIn_src_req = addr[9:0] ^ 10'h155;
        rbusIn_dst_req = dst;
        rbusIn_address = addr;
        ej_ready       = rdy;
    endtask

    task automatic idle(input logic rdy);
        rbusIn_signals = 4'b0000;
        rbusIn_src_req = 10'd0;
        rbusIn_dst_req = 10'd0;
        rbusIn_address = 37'd0;
        ej_ready       = rdy;
    endtask

    initial begin
        vec_t        v;
        logic [46:0] exp;

        // ---------------- stimulus table ----------------
        //                used  dst     addr      rdy   eUsed eCnt  eInCan eOvf
        vecs[0]  = '{1'b1, 10'd5, 37'h1234, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0}; // pass-through
        vecs[1]  = '{1'b0, 10'd3, 37'h00AA, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0}; // unused beat to us
        vecs[2]  = '{1'b1, 10'd3, 37'h0100, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 10'd3, 37'h0101, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 10'd3, 37'h0102, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0}; // in_can drops at 3
        vecs[5]  = '{1'b1, 10'd3, 37'h0103, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0}; // full
        // 10 continuous push+pop beats at full, walking both pointers round twice
        for (int i = 0; i < 10; i++) begin
            vecs[6 + i] = '{1'b1, 10'd3, 37'h0104 + 37'(i), 1'b1, 1'b0, 3'd4, 1'b0, 1'b0};
        end
        vecs[16] = '{1'b0, 10'd0, 37'h0000, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 10'd0, 37'h0000, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 10'd0, 37'h0000, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0};
        vecs[19] = '{1'b1, 10'd3, 37'h0200, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 10'd3, 37'h0201, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0};
        vecs[21] = '{1'b1, 10'd3, 37'h0202, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1}; // full, recirculate
        vecs[22] = '{1'b0, 10'd0, 37'h0000, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1}; // overflow sticky
        vecs[23] = '{1'b0, 10'd0, 37'h0000, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1};
        vecs[24] = '{1'b0, 10'd0, 37'h0000, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1};
        vecs[25] = '{1'b0, 10'd0, 37'h0000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1};

        // ---------------- reset and idle ----------------
        idle(1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_valid", 64'(ej_valid), 64'd0);
        chk("rst_count", 64'(ej_count), 64'd0);
        chk("rst_in_can", 64'(in_can), 64'd1);
        chk("rst_fwd_used", 64'(rbusOut_signals[`RBUS_USED]), 64'd0);
        chk("rst_ovf", 64'(ej_overflow), 64'd0);
        @(negedge clk);

        // ---------------- table ----------------
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            drive(v.used, v.dst, v.addr, v.rdy);
            if (v.used && (v.dst == 10'd3) && !v.eUsed)
                sb.push_back({v.addr[9:0] ^ 10'h155, v.addr});
            #1;
            if (ej_valid && ej_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'(sb.size()), 64'd1);
                end else begin
                    exp = sb.pop_front();
                    chk("ej_addr", 64'(ej_address), 64'(exp[36:0]));
                    chk("ej_src", 64'(ej_src_req), 64'(exp[46:37]));
                    chk("ej_sig", 64'(ej_signals), 64'(4'b1001));
                end
            end
            @(negedge clk);
            chk("fwd_sig", 64'(rbusOut_signals), 64'({2'b10, 1'b0, v.eUsed}));
            chk("fwd_dst", 64'(rbusOut_dst_req), 64'(v.dst));
            chk("fwd_addr", 64'(rbusOut_address), 64'(v.addr));
            chk("fwd_src", 64'(rbusOut_src_req), 64'(v.addr[9:0] ^ 10'h155));
            chk("count", 64'(ej_count), 64'(v.eCnt));
            chk("valid", 64'(ej_valid), 64'(v.eCnt != 3'd0));
            chk("in_can", 64'(in_can), 64'(v.eInCan));
            chk("ovf", 64'(ej_overflow), 64'(v.eOvf));
        end
        chk("sb_drained", 64'(sb.size()), 64'd0);

        // ---------------- reset mid-transfer ----------------
        drive(1'b1, 10'd3, 37'h0300, 1'b0);
        @(negedge clk);
        drive(1'b1, 10'd3, 37'h0301, 1'b0);
        @(negedge clk);
        chk("pre_rst_count", 64'(ej_count), 64'd2);
        idle(1'b0);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_count", 64'(ej_count), 64'd0);
        chk("mid_rst_valid", 64'(ej_valid), 64'd0);
        chk("mid_rst_ovf", 64'(ej_overflow), 64'd0);
        chk("mid_rst_fwd_sig", 64'(rbusOut_signals), 64'd0);
        chk("mid_rst_fwd_addr", 64'(rbusOut_address), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("no_replay_count", 64'(ej_count), 64'd0);
        chk("no_replay_valid", 64'(ej_valid), 64'd0);
        chk("no_replay_fwd", 64'(rbusOut_signals), 64'd0);

        // ---------------- empty FIFO, tile ready, matching beat ----------------
        drive(1'b1, 10'd3, 37'h55, 1'b1);
        #1;
`ifdef RBUS_EJECT_BYPASS_EN
        chk("byp_valid", 64'(ej_valid), 64'd1);
        chk("byp_addr", 64'(ej_address), 64'h55);
        chk("byp_count", 64'(ej_count), 64'd0);
        @(negedge clk);
        chk("byp_count_after", 64'(ej_count), 64'd0);
        chk("byp_fwd_used", 64'(rbusOut_signals[`RBUS_USED]), 64'd0);
        chk("byp_ovf", 64'(ej_overflow), 64'd0);
`else
        chk("nobyp_valid_now", 64'(ej_valid), 64'd0);
        @(negedge clk);
        idle(1'b1);
        #1;
        chk("nobyp_valid", 64'(ej_valid), 64'd1);
        chk("nobyp_addr", 64'(ej_address), 64'h55);
        chk("nobyp_count", 64'(ej_count), 64'd1);
        chk("nobyp_fwd_used", 64'(rbusOut_signals[`RBUS_USED]), 64'd0);
        @(negedge clk);
        chk("nobyp_drained", 64'(ej_count), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
